// File: rtl/pipelined_addsub.sv
// Carry-segmented add/subtract pipeline with optional signed saturation and a saturating overflow counter.
// Latency STAGES cycles at one beat/cycle; a stalled output freezes every stage and drops in_ready.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int SEG = WIDTH / STAGES;

    logic             advance;
    logic             stage_vld [0:STAGES-1];
    logic [WIDTH-1:0] stage_a   [0:STAGES-1];
    logic [WIDTH-1:0] stage_b   [0:STAGES-1];
    logic [WIDTH-1:0] stage_s   [0:STAGES-1];
    logic             stage_c   [0:STAGES-1];
    logic             stage_sat [0:STAGES-1];

    logic [WIDTH-1:0] nxt_s [0:STAGES-1];
    logic             nxt_c [0:STAGES-1];
    logic [SEG:0]     seg_sum;

    logic [WIDTH-1:0] raw_sum;
    logic             raw_cout;
    logic             raw_ovf;
    logic             last_a_msb;
    logic             last_b_msb;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] final_sum;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage k resolves segment k; stage_a/stage_b keep the untouched upper segments
    // skewed alongside, stage_s carries the finished lower sum bits forward.
    always_comb begin
        seg_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg_sum  = {1'b0, stage_a[k][k*SEG +: SEG]}
                     + {1'b0, stage_b[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, stage_c[k]};
            nxt_s[k] = stage_s[k];
            nxt_s[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            nxt_c[k] = seg_sum[SEG];
        end
    end

    assign raw_sum    = nxt_s[STAGES-1];
    assign raw_cout   = nxt_c[STAGES-1];
    assign last_a_msb = stage_a[STAGES-1][WIDTH-1];
    assign last_b_msb = stage_b[STAGES-1][WIDTH-1];
    // stage_b already holds ~B for subtract, so the sign rule covers both modes.
    assign raw_ovf    = (last_a_msb == last_b_msb) && (raw_sum[WIDTH-1] != last_a_msb);
    assign sat_val    = last_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign final_sum  = (stage_sat[STAGES-1] && raw_ovf) ? sat_val : raw_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_vld[k] <= 1'b0;
                stage_a[k]   <= '0;
                stage_b[k]   <= '0;
                stage_s[k]   <= '0;
                stage_c[k]   <= 1'b0;
                stage_sat[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            if (advance) begin
                stage_vld[0] <= in_valid;
                stage_a[0]   <= a;
                stage_b[0]   <= mode ? ~b : b;
                stage_s[0]   <= '0;
                stage_c[0]   <= mode;
                stage_sat[0] <= sat_en;
                for (int k = 1; k < STAGES; k++) begin
                    stage_vld[k] <= stage_vld[k-1];
                    stage_a[k]   <= stage_a[k-1];
                    stage_b[k]   <= stage_b[k-1];
                    stage_s[k]   <= nxt_s[k-1];
                    stage_c[k]   <= nxt_c[k-1];
                    stage_sat[k] <= stage_sat[k-1];
                end
                out_valid <= stage_vld[STAGES-1];
                if (stage_vld[STAGES-1]) begin
                    sum      <= final_sum;
                    cout     <= raw_cout;
                    overflow <= raw_ovf;
                end
            end
            if (out_valid && out_ready && overflow && (ovf_cnt != {CNT_W{1'b1}})) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed corner cases, backpressure, reset, counter saturation, random traffic.
module tb_pipelined_addsub;

    localparam int W       = 16;
    localparam int S       = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          mode;
    logic          sat_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          overflow;
    logic [CW-1:0] ovf_cnt;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .ovf_cnt(ovf_cnt)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_xfer = 0;
    int   mdl_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: signed integer arithmetic decides overflow and saturation, unsigned decides carry.
    function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xm, input logic xs);
        res_t   r;
        longint sa, sb, sr, ua, ub;
        longint maxp, minn;
        sa   = longint'($signed(xa));
        sb   = longint'($signed(xb));
        ua   = longint'(xa);
        ub   = longint'(xb);
        maxp = (longint'(1) << (W-1)) - 1;
        minn = -(longint'(1) << (W-1));
        sr   = xm ? (sa - sb) : (sa + sb);
        r.cout = xm ? (ua >= ub) : ((ua + ub) >= (longint'(1) << W));
        r.ovf  = (sr > maxp) || (sr < minn);
        r.sum  = W'(sr);
        if (xs && r.ovf) r.sum = (sr > 0) ? W'(maxp) : W'(minn);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Input side of the scoreboard: every accepted beat pushes its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) exp_q.push_back(model(a, b, mode, sat_en));
    end

    // Output side: every output transfer pops and compares; counter tracked alongside.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ovf_cnt_track", 32'(ovf_cnt), 32'(mdl_cnt));
            if (out_valid && out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sum=%h with no beat outstanding, required no output", sum);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", 32'({sum, cout, overflow}), 32'(mon_e));
                    if (mon_e.ovf && mdl_cnt < CNT_MAX) mdl_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: checks the fixed latency and the result against given constants.
    task automatic send_lat(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xm,
                            input logic xs, input logic [W-1:0] es, input logic ec,
                            input logic eo, input string name);
        int n;
        a = xa; b = xb; mode = xm; sat_en = xs; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(S));
        check({name, "_result"}, 32'({sum, cout, overflow}), 32'({es, ec, eo}));
        tick();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        mdl_cnt = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'({sum, cout, overflow}), 32'd0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bp_a [10];
        logic [W-1:0] bp_b [10];
        logic         bp_m [10];
        logic         bp_s [10];
        logic [17:0]  snap;
        int           sent, stall, x0, acc, n;
        bit           stall_done, last_acc;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; sat_en = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", 32'({sum, cout, overflow}), 32'd0);
        check("reset_ovf_cnt", 32'(ovf_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        tick();

        send_lat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_wrap");
        send_lat(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, "add_sat");
        tick();
        check("ovf_cnt_two", 32'(ovf_cnt), 32'd2);
        send_lat(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, "sub_sat");
        send_lat(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
        send_lat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry");
        send_lat(16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "sub_equal");

        // Backpressure: 10 back-to-back beats, 4-cycle stall once the first result shows.
        for (int i = 0; i < 10; i++) begin
            bp_a[i] = W'($urandom); bp_b[i] = W'($urandom);
            bp_m[i] = 1'($urandom); bp_s[i] = 1'($urandom);
        end
        sent = 0; stall = 0; stall_done = 1'b0; snap = '0; x0 = n_xfer;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (sent < 10) begin
                in_valid = 1'b1; a = bp_a[sent]; b = bp_b[sent]; mode = bp_m[sent]; sat_en = bp_s[sent];
            end else begin
                in_valid = 1'b0;
            end
            if (!stall_done && out_valid) begin
                stall_done = 1'b1;
                stall = 4;
                snap = {sum, cout, overflow};
            end
            out_ready = (stall == 0);
            #1;
            if (stall == 4) check("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (stall > 0) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_data", 32'({sum, cout, overflow}), 32'(snap));
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            if (stall > 0) stall--;
        end
        check("bp_sent", 32'(sent), 32'd10);
        check("bp_transfers", 32'(n_xfer - x0), 32'd10);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with three beats in flight; nothing stale may emerge afterwards.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = rnd_op(); b = rnd_op(); mode = 1'($urandom); sat_en = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        do_reset();
        send_lat(16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, "post_reset");
        for (int i = 0; i < 8; i++) tick();

        // Counter saturation: 17 overflowing results into a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; mode = 1'b0; sat_en = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("ovf_cnt_saturated", 32'(ovf_cnt), 32'(CNT_MAX));

        // Random traffic with random bubbles and random backpressure.
        do_reset();
        acc = 0; last_acc = 1'b1; in_valid = 1'b0;
        for (int cyc = 0; cyc < 40000 && acc < 10000; cyc++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(4) != 0);
                a = rnd_op(); b = rnd_op(); mode = 1'($urandom); sat_en = 1'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            last_acc = in_valid && in_ready;
            if (last_acc) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("random_accepted", 32'(acc), 32'd10000);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("random_drained", 32'(exp_q.size()), 32'd0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
